// File: rtl/cam_ctrl.sv
// rtl/cam_ctrl.sv - round-robin lookup/insert controller for an external CAM
// Define CAM_CTRL_FLUSH_EN to build in the sequenced flush of all entries.
module cam_ctrl #(
    parameter  int DATA  = 16,
    parameter  int DEPTH = 16,
    parameter  int NREQ  = 4,
    localparam int ADDR  = $clog2(DEPTH)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NREQ-1:0]           req,
    input  logic [NREQ-1:0][DATA-1:0] req_key,
    output logic [NREQ-1:0]           gnt,
    output logic                      resp_valid,
    output logic [NREQ-1:0]           resp_id,
    output logic                      resp_hit,
    output logic [ADDR-1:0]           resp_addr,
    output logic [ADDR:0]             occupancy,
    input  logic                      flush,
    output logic                      flush_done,
    output logic                      cam_we_,
    output logic [DATA:0]             cam_wm,
    output logic [DATA:0]             cam_wd,
    output logic [ADDR-1:0]           cam_waddr,
    output logic                      cam_re_,
    output logic [DATA:0]             cam_rm,
    output logic [DATA:0]             cam_rd,
    input  logic                      cam_match,
    input  logic [ADDR-1:0]           cam_raddr
);
    localparam int RRW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOOKUP,
        S_INSERT,
        S_RESP
`ifdef CAM_CTRL_FLUSH_EN
        , S_FLUSH
`endif
    } state_t;

    state_t            r_state, w_next;
    logic [RRW-1:0]    r_rr, w_win;
    logic [RRW:0]      w_idx;
    logic              w_any, w_take, w_flush_take;
    logic [ADDR-1:0]   r_victim, r_addr, r_resp_addr;
    logic [ADDR:0]     r_occ;
    logic [DATA-1:0]   r_key;
    logic [NREQ-1:0]   r_id, r_gnt, r_resp_id;
    logic              r_hit, r_resp_hit, r_resp_valid;

`ifdef CAM_CTRL_FLUSH_EN
    logic [ADDR-1:0]   r_fcnt;
    logic              r_flush_done;
    // flush still held while flush_done is showing is the finished request, not a new one
    assign w_flush_take = (r_state == S_IDLE) && flush && !r_flush_done;
    assign flush_done   = r_flush_done;
`else
    logic              w_unused_flush;
    assign w_unused_flush = flush;
    assign w_flush_take   = 1'b0;
    assign flush_done     = 1'b0;
`endif

    always_comb begin
        w_any = 1'b0;
        w_win = '0;
        w_idx = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            w_idx = {1'b0, r_rr} + (RRW+1)'(i);
            if (w_idx >= (RRW+1)'(NREQ)) w_idx = w_idx - (RRW+1)'(NREQ);
            if (req[w_idx[RRW-1:0]]) begin
                w_any = 1'b1;
                w_win = w_idx[RRW-1:0];
            end
        end
    end

    assign w_take = (r_state == S_IDLE) && w_any && !w_flush_take;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next    = r_state;
        cam_we_   = 1'b1;
        cam_re_   = 1'b1;
        cam_waddr = r_victim;
        cam_wd    = {1'b1, r_key};
        case (r_state)
            S_IDLE: begin
                if (w_flush_take) begin
`ifdef CAM_CTRL_FLUSH_EN
                    w_next = S_FLUSH;
`endif
                end else if (w_any) begin
                    w_next = S_LOOKUP;
                end
            end
            S_LOOKUP: begin
                cam_re_ = 1'b0;
                w_next  = cam_match ? S_RESP : S_INSERT;
            end
            S_INSERT: begin
                cam_we_ = 1'b0;
                w_next  = S_RESP;
            end
            S_RESP: w_next = S_IDLE;
`ifdef CAM_CTRL_FLUSH_EN
            S_FLUSH: begin
                cam_we_   = 1'b0;
                cam_waddr = r_fcnt;
                cam_wd    = '0;
                if (r_fcnt == ADDR'(DEPTH - 1)) w_next = S_IDLE;
            end
`endif
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rr         <= '0;
            r_victim     <= '0;
            r_occ        <= '0;
            r_key        <= '0;
            r_id         <= '0;
            r_hit        <= 1'b0;
            r_addr       <= '0;
            r_gnt        <= '0;
            r_resp_valid <= 1'b0;
            r_resp_id    <= '0;
            r_resp_hit   <= 1'b0;
            r_resp_addr  <= '0;
`ifdef CAM_CTRL_FLUSH_EN
            r_fcnt       <= '0;
            r_flush_done <= 1'b0;
`endif
        end else begin
            r_gnt        <= '0;
            r_resp_valid <= 1'b0;
`ifdef CAM_CTRL_FLUSH_EN
            r_flush_done <= 1'b0;
`endif
            if (w_take) begin
                r_gnt <= NREQ'(1) << w_win;
                r_id  <= NREQ'(1) << w_win;
                r_key <= req_key[w_win];
                r_rr  <= (w_win == RRW'(NREQ - 1)) ? '0 : w_win + RRW'(1);
            end
            case (r_state)
                S_LOOKUP: begin
                    r_hit  <= cam_match;
                    r_addr <= cam_raddr;
                end
                S_INSERT: begin
                    r_addr   <= r_victim;
                    r_victim <= r_victim + ADDR'(1);
                    if (r_occ != (ADDR+1)'(DEPTH)) r_occ <= r_occ + (ADDR+1)'(1);
                end
                S_RESP: begin
                    r_resp_valid <= 1'b1;
                    r_resp_id    <= r_id;
                    r_resp_hit   <= r_hit;
                    r_resp_addr  <= r_addr;
                end
`ifdef CAM_CTRL_FLUSH_EN
                S_FLUSH: begin
                    r_fcnt <= r_fcnt + ADDR'(1);
                    if (r_fcnt == ADDR'(DEPTH - 1)) begin
                        r_occ        <= '0;
                        r_victim     <= '0;
                        r_flush_done <= 1'b1;
                    end
                end
`endif
                default: ;
            endcase
        end
    end

    assign gnt        = r_gnt;
    assign resp_valid = r_resp_valid;
    assign resp_id    = r_resp_id;
    assign resp_hit   = r_resp_hit;
    assign resp_addr  = r_resp_addr;
    assign occupancy  = r_occ;
    assign cam_wm     = '0;
    assign cam_rm     = '0;
    assign cam_rd     = {1'b1, r_key};

endmodule

// File: tb/tb_cam_ctrl.sv
// tb/tb_cam_ctrl.sv - randomized self-checking bench for cam_ctrl against a CAM reference model
module tb_cam_ctrl;
    localparam int DATA  = 16;
    localparam int DEPTH = 16;
    localparam int NREQ  = 4;
    localparam int ADDR  = $clog2(DEPTH);

    logic                      clk = 1'b0;
    logic                      reset;
    logic [NREQ-1:0]           req;
    logic [NREQ-1:0][DATA-1:0] req_key;
    logic [NREQ-1:0]           gnt;
    logic                      resp_valid;
    logic [NREQ-1:0]           resp_id;
    logic                      resp_hit;
    logic [ADDR-1:0]           resp_addr;
    logic [ADDR:0]             occupancy;
    logic                      flush;
    logic                      flush_done;
    logic                      cam_we_;
    logic [DATA:0]             cam_wm;
    logic [DATA:0]             cam_wd;
    logic [ADDR-1:0]           cam_waddr;
    logic                      cam_re_;
    logic [DATA:0]             cam_rm;
    logic [DATA:0]             cam_rd;
    logic                      cam_match;
    logic [ADDR-1:0]           cam_raddr;

    cam_ctrl #(.DATA(DATA), .DEPTH(DEPTH), .NREQ(NREQ)) dut (
        .clk(clk), .reset(reset), .req(req), .req_key(req_key), .gnt(gnt),
        .resp_valid(resp_valid), .resp_id(resp_id), .resp_hit(resp_hit),
        .resp_addr(resp_addr), .occupancy(occupancy), .flush(flush),
        .flush_done(flush_done), .cam_we_(cam_we_), .cam_wm(cam_wm), .cam_wd(cam_wd),
        .cam_waddr(cam_waddr), .cam_re_(cam_re_), .cam_rm(cam_rm), .cam_rd(cam_rd),
        .cam_match(cam_match), .cam_raddr(cam_raddr)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // CAM array attached to the controller
    logic [DATA:0] cam_mem [DEPTH];
    always_comb begin
        cam_match = 1'b0;
        cam_raddr = '0;
        for (int a = DEPTH - 1; a >= 0; a--)
            if (cam_mem[a] == cam_rd) begin
                cam_match = 1'b1;
                cam_raddr = ADDR'(a);
            end
    end
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int a = 0; a < DEPTH; a++) cam_mem[a] <= '0;
        end else if (!cam_we_) begin
            cam_mem[cam_waddr] <= cam_wd;
        end
    end

    int            cyc_cnt  = 0;
    int            n_lookup = 0;
    logic [DATA:0] last_rd  = '0;
    logic [ADDR-1:0] wq_addr[$];
    logic [DATA:0]   wq_data[$];
    int              wq_cyc[$];

    always @(posedge clk) begin
        cyc_cnt <= cyc_cnt + 1;
        if (!reset) begin
            if (!cam_re_) begin
                n_lookup <= n_lookup + 1;
                last_rd  <= cam_rd;
            end
            if (!cam_we_) begin
                wq_addr.push_back(cam_waddr);
                wq_data.push_back(cam_wd);
                wq_cyc.push_back(cyc_cnt);
            end
            if (!cam_we_ && !cam_re_) check("we_re_both_low", {cam_we_, cam_re_}, 2'b11);
            if (cam_wm != '0) check("cam_wm", cam_wm, 0);
            if (cam_rm != '0) check("cam_rm", cam_rm, 0);
        end
    end

    // reference model: entry contents, victim, occupancy, arbitration pointer
    logic [DATA-1:0] m_key [DEPTH];
    bit              m_val [DEPTH];
    int              m_rr, m_victim, m_occ;

    task automatic model_clear(input bit clear_rr);
        for (int a = 0; a < DEPTH; a++) begin
            m_val[a] = 1'b0;
            m_key[a] = '0;
        end
        m_victim = 0;
        m_occ    = 0;
        if (clear_rr) m_rr = 0;
    endtask

    task automatic clear_wq();
        wq_addr.delete();
        wq_data.delete();
        wq_cyc.delete();
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_gnt"}, gnt, 0);
        check({tag, "_resp_valid"}, resp_valid, 0);
        check({tag, "_resp_id"}, resp_id, 0);
        check({tag, "_resp_hit"}, resp_hit, 0);
        check({tag, "_resp_addr"}, resp_addr, 0);
        check({tag, "_occupancy"}, occupancy, 0);
        check({tag, "_flush_done"}, flush_done, 0);
        check({tag, "_cam_we_"}, cam_we_, 1);
        check({tag, "_cam_re_"}, cam_re_, 1);
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        req   = '0;
        flush = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_vals("rst");
        reset = 1'b0;
        model_clear(1'b1);
    endtask

    task automatic do_op(input logic [NREQ-1:0] mask);
        int win, exp_addr, lat, start_lk;
        bit exp_hit;
        logic [DATA-1:0] k;
        win = -1;
        for (int i = 0; i < NREQ; i++)
            if (win < 0 && mask[(m_rr + i) % NREQ]) win = (m_rr + i) % NREQ;
        k        = req_key[win];
        exp_hit  = 1'b0;
        exp_addr = m_victim;
        for (int a = 0; a < DEPTH; a++)
            if (m_val[a] && m_key[a] == k) begin
                exp_hit  = 1'b1;
                exp_addr = a;
            end
        clear_wq();
        start_lk = n_lookup;
        req = mask;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (gnt == '0 && lat < 100);
        check("gnt", gnt, 32'd1 << win);
        if (gnt == '0) begin
            req = '0;
            return;
        end
        req[win] = 1'b0;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
            if (gnt != '0) check("gnt_while_busy", gnt, 0);
        end while (!resp_valid && lat < 10);
        check("latency", lat, exp_hit ? 2 : 3);
        check("resp_id", resp_id, 32'd1 << win);
        check("resp_hit", resp_hit, exp_hit);
        check("resp_addr", resp_addr, exp_addr);
        m_rr = (win + 1) % NREQ;
        if (!exp_hit) begin
            m_key[m_victim] = k;
            m_val[m_victim] = 1'b1;
            m_victim = (m_victim + 1) % DEPTH;
            if (m_occ < DEPTH) m_occ++;
        end
        check("occupancy", occupancy, m_occ);
        check("lookups", n_lookup - start_lk, 1);
        check("cam_rd", last_rd, {1'b1, k});
        check("writes", wq_addr.size(), exp_hit ? 0 : 1);
        if (!exp_hit && wq_addr.size() > 0) begin
            check("waddr", wq_addr[0], exp_addr);
            check("wdata", wq_data[0], {1'b1, k});
        end
    endtask

    task automatic do_flush(input logic [NREQ-1:0] mask);
        int lat;
        bit ok;
        clear_wq();
`ifdef CAM_CTRL_FLUSH_EN
        flush = 1'b1;
        req   = mask;
        lat   = 0;
        do begin
            @(negedge clk);
            lat++;
            if (gnt != '0) check("flush_gnt", gnt, 0);
        end while (!flush_done && lat < DEPTH + 10);
        flush = 1'b0;
        check("flush_latency", lat, DEPTH + 1);
        check("flush_nwr", wq_addr.size(), DEPTH);
        ok = (wq_addr.size() == DEPTH);
        for (int i = 0; i < wq_addr.size(); i++)
            if (wq_addr[i] != ADDR'(i) || wq_data[i] != '0 || wq_cyc[i] != wq_cyc[0] + i) ok = 1'b0;
        check("flush_wr_seq", ok, 1);
        check("flush_occ", occupancy, 0);
        model_clear(1'b0);
        if (mask != '0) do_op(mask);
`else
        flush = 1'b1;
        req   = '0;
        ok    = 1'b1;
        repeat (5) begin
            @(negedge clk);
            if (flush_done) ok = 1'b0;
        end
        check("flush_done_tied", ok, 1);
        check("flush_ign_occ", occupancy, m_occ);
        check("flush_ign_wr", wq_addr.size(), 0);
        if (mask != '0) do_op(mask);
        flush = 1'b0;
`endif
    endtask

    task automatic do_reset_mid_insert();
        int lat;
        bit ok;
        for (int i = 0; i < NREQ; i++) req_key[i] = 16'hBEEF;
        req = '1;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (gnt == '0 && lat < 100);
        check("rmi_gnt_seen", gnt != '0, 1);
        req = '0;
        @(negedge clk);
        check("rmi_in_insert", cam_we_, 0);
        reset = 1'b1;
        #1;
        check_reset_vals("rmi_async");
        @(negedge clk);
        check_reset_vals("rmi_held");
        reset = 1'b0;
        model_clear(1'b1);
        ok = 1'b1;
        repeat (4) begin
            @(negedge clk);
            if (resp_valid) ok = 1'b0;
        end
        check("rmi_no_resp", ok, 1);
        req_key[1] = 16'h0A0A;
        req_key[2] = 16'h0B0B;
        do_op(4'b0110);
        check("rmi_first_id", resp_id, 4'b0010);
    endtask

    initial begin
        reset   = 1'b1;
        req     = '0;
        flush   = 1'b0;
        req_key = '0;
        apply_reset();

        req_key[0] = 16'h1234;
        do_op(4'b0001);
        check("ins_addr", resp_addr, 0);
        check("ins_occ", occupancy, 1);
        req_key[2] = 16'h1234;
        do_op(4'b0100);
        check("hit_flag", resp_hit, 1);
        check("hit_id", resp_id, 4'b0100);

        apply_reset();
        for (int i = 0; i < NREQ; i++) req_key[i] = DATA'(16'h0200 + i);
        for (int n = 0; n < 5; n++) begin
            do_op(4'b1111);
            check("fair_order", resp_id, 32'd1 << (n % NREQ));
        end

        apply_reset();
        for (int n = 0; n <= DEPTH; n++) begin
            req_key[0] = DATA'(16'h0100 + n);
            do_op(4'b0001);
        end
        check("wrap_occ", occupancy, DEPTH);
        check("wrap_last_addr", resp_addr, 0);
        req_key[0] = 16'h0100;
        do_op(4'b0001);
        check("wrap_first_miss", resp_hit, 0);

        for (int n = 0; n < 60; n++) begin
            for (int i = 0; i < NREQ; i++) req_key[i] = DATA'($urandom_range(0, 23));
            if ($urandom_range(0, 14) == 0) do_flush(NREQ'($urandom_range(0, 15)));
            else                            do_op(NREQ'($urandom_range(1, 15)));
        end

        req_key[1] = 16'h5A5A;
        do_flush(4'b0010);
        check("post_flush_miss", resp_hit, 0);

        do_reset_mid_insert();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/cam_ctrl.md
CAM_CTRL -- requirements
Module: cam_ctrl

Interface
REQ-001 SHALL have parameters, one per line:
- DATA, 16, key width.
- DEPTH, 16, CAM entries (power of 2, >=2).
- NREQ, 4, requesters.
- ADDR, $clog2(DEPTH), derived, not overridden.
REQ-002 SHALL have ports, one per line:
- clk  in  1  sole clock; all state on rising edge.
- reset  in  1  asynchronous, active-high reset.
- req  in  NREQ  lookup-or-insert request per requester; held until granted.
- req_key  in  NREQ x DATA  key per requester.
- gnt  out  NREQ  one-hot grant pulse.
- resp_valid  out  1  response pulse.
- resp_id  out  NREQ  one-hot owner of the response.
- resp_hit  out  1  1 = key already present, 0 = newly inserted.
- resp_addr  out  ADDR  entry holding the key.
- occupancy  out  ADDR+1  valid entry count.
- flush  in  1  invalidate all entries.
- flush_done  out  1  flush completion pulse.
- cam_we_  out  1  CAM write enable, active-low.
- cam_wm  out  DATA+1  CAM write mask; always 0.
- cam_wd  out  DATA+1  CAM write data; bit DATA = valid.
- cam_waddr  out  ADDR  CAM write address.
- cam_re_  out  1  CAM search enable, active-low.
- cam_rm  out  DATA+1  CAM search mask; always 0.
- cam_rd  out  DATA+1  CAM search data {1'b1, key}.
- cam_match  in  1  CAM hit, combinational from cam_rd.
- cam_raddr  in  ADDR  CAM hit address.

Function
REQ-003 SHALL implement FSM IDLE, LOOKUP, INSERT, RESP, FLUSH; one operation outstanding at a time.
REQ-004 In IDLE with any req set, SHALL pulse gnt for one cycle to the round-robin winner, latch its key and id, and go to LOOKUP.
REQ-005 Round-robin priority SHALL start at requester 0 after reset and move to (last granted + 1) mod NREQ after each grant.
REQ-006 In LOOKUP, SHALL drive cam_re_=0 and cam_rd={1'b1,key} for exactly one cycle and sample cam_match/cam_raddr that cycle.
REQ-007 On hit, SHALL go to RESP with resp_hit=1 and resp_addr=cam_raddr.
REQ-008 On miss, SHALL go to INSERT and drive cam_we_=0, cam_waddr=victim pointer, cam_wd={1'b1,key} for one cycle, then go to RESP with resp_hit=0 and resp_addr=victim pointer.
REQ-009 The victim pointer SHALL increment after each insert and wrap from DEPTH-1 to 0; when occupancy=DEPTH the oldest entry is overwritten.
REQ-010 occupancy SHALL increment on insert while below DEPTH and saturate at DEPTH.
REQ-011 RESP SHALL assert resp_valid and resp_id for one cycle and return to IDLE.
REQ-012 Latency from grant cycle T SHALL be resp_valid at T+2 on hit and T+3 on miss.
REQ-013 The next grant SHALL be no earlier than the cycle after resp_valid.
REQ-014 cam_we_ and cam_re_ SHALL be 1 in every state not listed above; they SHALL never both be 0 in the same cycle.
REQ-015 gnt, resp_valid and flush_done SHALL be registered outputs; resp fields SHALL hold their values between responses.

Reset
REQ-016 reset SHALL asynchronously force: FSM=IDLE, round-robin priority=0, victim pointer=0, occupancy=0, gnt=0, resp_valid=0, resp_id=0, resp_hit=0, resp_addr=0, flush_done=0, cam_we_=1, cam_re_=1.
REQ-017 reset asserted mid-operation SHALL abandon the operation with no response; the CAM array itself is cleared by its own reset.

Configuration
REQ-018 Macro CAM_CTRL_FLUSH_EN SHALL compile the flush feature in.
REQ-019 With CAM_CTRL_FLUSH_EN defined, flush sampled in IDLE SHALL take priority over req (no gnt that cycle) and enter FLUSH.
REQ-020 FLUSH SHALL write cam_wd=0 to addresses 0..DEPTH-1, one per cycle over DEPTH cycles, then set occupancy=0 and victim pointer=0, pulse flush_done for one cycle, and return to IDLE.
REQ-021 flush outside IDLE SHALL be ignored; the requester holds it until flush_done.
REQ-022 Without CAM_CTRL_FLUSH_EN, flush SHALL be ignored, flush_done SHALL be tied to 0, and no FLUSH state SHALL exist.

Verification
REQ-023 Insert: req[0] key 0x1234 into empty CAM -> gnt[0] at T, resp_valid at T+3, resp_hit=0, resp_addr=0, occupancy=1.
REQ-024 Hit: repeat key 0x1234 from req[2] -> resp_valid at T+2, resp_hit=1, resp_addr=0, resp_id=4'b0100, occupancy unchanged.
REQ-025 Fairness: req=4'b1111 held continuously -> gnt order 0,1,2,3,0, one grant per completed response.
REQ-026 Wrap: DEPTH+1 distinct keys inserted -> occupancy saturates at 16, last key at resp_addr=0, first key then misses.
REQ-027 Flush (macro on): flush with req pending -> 16 consecutive writes of 0 to addresses 0..15, flush_done pulse, occupancy=0, then the pending req is granted and misses.
REQ-028 Reset mid-INSERT -> all outputs at reset values next cycle, no resp_valid, first post-reset grant goes to lowest requesting index.
